buzzer_sequencer: RTL and testbench

BUZZER_SEQUENCER -- requirements
Module: buzzer_sequencer

---
 rtl/buzzer_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_buzzer_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : buzzer_sequencer
// Description : Memory-mapped note FIFO driving a square-wave buzzer; the
//               optional irq output is built when BUZZER_SEQUENCER_IRQ_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
module buzzer_sequencer #(
    parameter int          FIFO_DEPTH     = 4,
    parameter logic [15:0] TICK_DIV_RESET = 16'd3000
) (
    input  logic        clock,
    input  logic        n_reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] low_address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        buzzer
`ifdef BUZZER_SEQUENCER_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int           AW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]  c_DEPTH     = (AW+1)'(FIFO_DEPTH);
    localparam logic [1:0]   c_ADDR_NOTE = 2'd0;
    localparam logic [1:0]   c_ADDR_STAT = 2'd1;
    localparam logic [1:0]   c_ADDR_CTRL = 2'd2;
    localparam logic [1:0]   c_ADDR_TDIV = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_t;

    state_t        state_q;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          overflow_q;
    logic          enable_q;
    logic [15:0]   tick_div_q;
    logic [31:0]   note_q;
    logic [15:0]   dur_cnt_q;
    logic [15:0]   hp_cnt_q;
    logic [15:0]   presc_q;
    logic          buzzer_q;
    logic          w_irq_en_rd;

    logic [1:0]  w_sel;
    logic        w_note_wr;
    logic        w_ctrl_wr;
    logic        w_tdiv_wr;
    logic        w_flush;
    logic        w_ovf_clr;
    logic        w_empty;
    logic        w_full;
    logic        w_abort;
    logic        w_pop;
    logic        w_push;
    logic        w_push_ok;
    logic        w_push_drop;
    logic [15:0] w_tdiv_eff;
    logic [31:0] w_status;
    logic        w_unused_addr;

    assign w_sel         = low_address[3:2];
    assign w_unused_addr = &{1'b0, low_address[15:4], low_address[1:0]};
    assign w_note_wr     = cs && write && (w_sel == c_ADDR_NOTE);
    assign w_ctrl_wr     = cs && write && (w_sel == c_ADDR_CTRL);
    assign w_tdiv_wr     = cs && write && (w_sel == c_ADDR_TDIV);
    assign w_flush       = w_ctrl_wr && data_in[1];
    assign w_ovf_clr     = w_ctrl_wr && data_in[2];
    assign w_empty       = (count_q == '0);
    assign w_full        = (count_q == c_DEPTH);
    // Any enable clear or flush aborts playback on this very edge.
    assign w_abort       = !enable_q || (w_ctrl_wr && (!data_in[0] || data_in[1]));
    assign w_pop         = (state_q == IDLE) && !w_empty && !w_abort;
    assign w_push        = w_note_wr && !w_flush;
    assign w_push_ok     = w_push && (!w_full || w_pop);
    assign w_push_drop   = w_push && w_full && !w_pop;
    assign w_tdiv_eff    = (tick_div_q == 16'd0) ? 16'd1 : tick_div_q;
    assign buzzer        = buzzer_q;

    always_comb begin
        count_d = count_q;
        case ({w_push_ok, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            enable_q   <= 1'b0;
            tick_div_q <= TICK_DIV_RESET;
        end else begin
            if (w_flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (w_push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (w_pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
                count_q <= count_d;
            end
            if (w_push_drop)    overflow_q <= 1'b1;
            else if (w_ovf_clr) overflow_q <= 1'b0;
            if (w_ctrl_wr) enable_q   <= data_in[0];
            if (w_tdiv_wr) tick_div_q <= data_in[15:0];
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= IDLE;
            note_q    <= '0;
            dur_cnt_q <= '0;
            hp_cnt_q  <= '0;
            presc_q   <= '0;
            buzzer_q  <= 1'b0;
        end else if (w_abort) begin
            state_q  <= IDLE;
            buzzer_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    buzzer_q <= 1'b0;
                    if (w_pop) begin
                        note_q  <= mem_q[rd_ptr_q];
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    buzzer_q  <= 1'b0;
                    dur_cnt_q <= note_q[31:16];
                    hp_cnt_q  <= note_q[15:0];
                    presc_q   <= w_tdiv_eff - 16'd1;
                    state_q   <= (note_q[31:16] == 16'd0) ? IDLE : PLAY;
                end
                PLAY: begin
                    if (note_q[15:0] == 16'd0) begin
                        buzzer_q <= 1'b0;
                    end else if (hp_cnt_q == 16'd1) begin
                        buzzer_q <= ~buzzer_q;
                        hp_cnt_q <= note_q[15:0];
                    end else begin
                        hp_cnt_q <= hp_cnt_q - 16'd1;
                    end
                    // End of note overrides any toggle on the same edge.
                    if (presc_q == 16'd0) begin
                        presc_q   <= w_tdiv_eff - 16'd1;
                        dur_cnt_q <= dur_cnt_q - 16'd1;
                        if (dur_cnt_q == 16'd1) begin
                            state_q  <= IDLE;
                            buzzer_q <= 1'b0;
                        end
                    end else begin
                        presc_q <= presc_q - 16'd1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    buzzer_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef BUZZER_SEQUENCER_IRQ_EN
    logic irq_en_q;
    logic irq_q;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (w_ctrl_wr) irq_en_q <= data_in[3];
            irq_q <= irq_en_q && w_empty && (state_q == IDLE);
        end
    end

    assign w_irq_en_rd = irq_en_q;
    assign irq         = irq_q;
`else
    assign w_irq_en_rd = 1'b0;
`endif

    assign w_status = {23'd0, overflow_q, 4'(count_q), 1'b0,
                       w_empty, w_full, (state_q != IDLE)};

    always_comb begin
        data_out = 32'd0;
        if (cs && read) begin
            case (w_sel)
                c_ADDR_STAT: data_out = w_status;
                c_ADDR_CTRL: data_out = {28'd0, w_irq_en_rd, 2'b00, enable_q};
                c_ADDR_TDIV: data_out = {16'd0, tick_div_q};
                default:     data_out = 32'd0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_buzzer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_buzzer_sequencer
// Description : Directed scoreboard bench for buzzer_sequencer (honours
//               BUZZER_SEQUENCER_IRQ_EN for the irq checks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buzzer_sequencer;

    logic        clock;
    logic        n_reset;
    logic        cs;
    logic        read;
    logic        write;
    logic [15:0] low_address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        buzzer;
    logic        irq_w;

    logic        dchk;
    logic        pchk;
    logic        psel;
    logic [31:0] exp_q[$];
    string       nm_q[$];
    logic        bexp_q[$];
    string       bnm_q[$];
    int          n_checks;
    int          n_pass;

    buzzer_sequencer #(
        .FIFO_DEPTH    (4),
        .TICK_DIV_RESET(16'd3000)
    ) dut (
        .clock      (clock),
        .n_reset    (n_reset),
        .cs         (cs),
        .read       (read),
        .write      (write),
        .low_address(low_address),
        .data_in    (data_in),
        .data_out   (data_out),
        .buzzer     (buzzer)
`ifdef BUZZER_SEQUENCER_IRQ_EN
        ,
        .irq        (irq_w)
`endif
    );

`ifndef BUZZER_SEQUENCER_IRQ_EN
    assign irq_w = 1'b0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: compares whenever the bench presents a read or a probe.
    always @(negedge clock) begin
        if (dchk) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL data_out: no expectation queued, got 0x%08h", data_out);
            end else begin
                logic [31:0] e;
                string       nm;
                e  = exp_q.pop_front();
                nm = nm_q.pop_front();
                if (data_out === e) n_pass++;
                else $display("FAIL %s: data_out=0x%08h expected 0x%08h", nm, data_out, e);
            end
        end
        if (pchk) begin
            n_checks++;
            if (bexp_q.size() == 0) begin
                $display("FAIL probe: no expectation queued");
            end else begin
                logic  e;
                logic  a;
                string nm;
                e  = bexp_q.pop_front();
                nm = bnm_q.pop_front();
                a  = psel ? irq_w : buzzer;
                if (a === e) n_pass++;
                else $display("FAIL %s: got %b expected %b", nm, a, e);
            end
        end
    end

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; low_address = a; data_in = d;
        @(posedge clock); #1;
        cs = 1'b0; write = 1'b0; data_in = 32'd0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [31:0] e, input string nm);
        exp_q.push_back(e); nm_q.push_back(nm);
        cs = 1'b1; read = 1'b1; low_address = a; dchk = 1'b1;
        @(posedge clock); #1;
        cs = 1'b0; read = 1'b0; dchk = 1'b0;
    endtask

    task automatic dout_idle(input string nm);
        exp_q.push_back(32'd0); nm_q.push_back(nm);
        cs = 1'b1; read = 1'b0; low_address = 16'h0004; dchk = 1'b1;
        @(posedge clock); #1;
        cs = 1'b0; dchk = 1'b0;
    endtask

    task automatic chk_bit(input logic sel, input logic e, input string nm);
        bexp_q.push_back(e); bnm_q.push_back(nm);
        psel = sel; pchk = 1'b1;
        @(posedge clock); #1;
        pchk = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] pat29;
        logic [5:0]  pat31;
        logic [6:0]  pat_t0;
        logic [4:0]  pat_irq;
        pat29   = 11'h0E0;
        pat31   = 6'b100000;
        pat_t0  = 7'b0001000;
        pat_irq = 5'b10001;
        n_checks = 0; n_pass = 0;
        n_reset = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0;
        low_address = 16'd0; data_in = 32'd0;
        dchk = 1'b0; pchk = 1'b0; psel = 1'b0;
        repeat (3) @(posedge clock);
        #1 n_reset = 1'b1;

        // Reset state
        rd(16'h4, 32'h4, "rst_status");
        rd(16'hC, 32'hBB8, "rst_tickdiv");
        rd(16'h8, 32'h0, "rst_control");
        chk_bit(1'b0, 1'b0, "rst_buzzer");
        dout_idle("dout_without_read");

        // Basic note: toggle every 3 clocks, 8 clocks of PLAY
        wr(16'hC, 32'd4);
        wr(16'h8, 32'h1);
        wr(16'h0, 32'h0002_0003);
        for (int k = 0; k < 11; k++) chk_bit(1'b0, pat29[k], $sformatf("note_buz%0d", k));
        rd(16'h4, 32'h4, "note_done_status");

        // Overflow with enable off
        wr(16'h8, 32'h0);
        for (int k = 0; k < 5; k++) wr(16'h0, 32'h0005_0003);
        rd(16'h4, 32'h142, "overflow_status");
        rd(16'h8, 32'h0, "ctrl_disabled");
        wr(16'h8, 32'h4);
        rd(16'h4, 32'h42, "ovf_cleared_status");

        // Abort mid-note by clearing enable
        wr(16'h8, 32'h1);
        for (int k = 0; k < 6; k++) chk_bit(1'b0, pat31[k], $sformatf("abort_buz%0d", k));
        wr(16'h8, 32'h0);
        chk_bit(1'b0, 1'b0, "abort_buzzer");
        rd(16'h4, 32'h30, "abort_status");

        // Flush while playing
        wr(16'h8, 32'h2);
        rd(16'h4, 32'h4, "flush_idle_status");
        wr(16'h8, 32'h1);
        for (int k = 0; k < 3; k++) wr(16'h0, 32'h0005_0003);
        wr(16'h8, 32'h3);
        chk_bit(1'b0, 1'b0, "flush_buzzer");
        rd(16'h4, 32'h4, "flush_status");
        rd(16'h8, 32'h1, "flush_ctrl");
        repeat (3) @(posedge clock);
        #1;
        rd(16'h4, 32'h4, "flush_still_idle");

        // TICK_DIV 0 behaves as 1, half period 1 toggles each clock
        wr(16'hC, 32'd0);
        rd(16'hC, 32'd0, "tickdiv_zero_raw");
        wr(16'h0, 32'h0003_0001);
        for (int k = 0; k < 7; k++) chk_bit(1'b0, pat_t0[k], $sformatf("tdiv0_buz%0d", k));

        // Rest note keeps buzzer low
        wr(16'h0, 32'h0002_0000);
        for (int k = 0; k < 5; k++) chk_bit(1'b0, 1'b0, $sformatf("rest_buz%0d", k));

        // Zero-duration note is skipped after LOAD
        wr(16'h0, 32'h0000_0005);
        rd(16'h4, 32'h10, "zdur_queued");
        rd(16'h4, 32'h5, "zdur_load");
        rd(16'h4, 32'h4, "zdur_idle");

        // Push while full with simultaneous pop is accepted
        wr(16'h8, 32'h2);
        for (int k = 0; k < 4; k++) wr(16'h0, 32'h0005_0003);
        wr(16'h8, 32'h1);
        wr(16'h0, 32'h0005_0003);
        rd(16'h4, 32'h43, "full_push_pop");
        wr(16'h8, 32'h2);
        rd(16'h4, 32'h4, "full_flushed");

        // CONTROL bit3 and irq
        wr(16'h8, 32'h9);
`ifdef BUZZER_SEQUENCER_IRQ_EN
        chk_bit(1'b1, 1'b0, "irq_before");
        chk_bit(1'b1, 1'b1, "irq_idle_empty");
        wr(16'h0, 32'h0001_0002);
        for (int k = 0; k < 5; k++) chk_bit(1'b1, pat_irq[k], $sformatf("irq_seq%0d", k));
        rd(16'h8, 32'h9, "ctrl_irq_en");
`else
        rd(16'h8, 32'h1, "ctrl_bit3_ignored");
`endif

        repeat (2) @(posedge clock);
        #1;
        if (exp_q.size() != 0 || bexp_q.size() != 0) begin
            n_checks++;
            $display("FAIL leftover: %0d/%0d expectations unconsumed, required 0/0",
                     exp_q.size(), bexp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
